// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared constants for the bit-serial adder:
//     - FSM state encodings (two-bit, legacy-compatible localparams)
//     - legal range of the WIDTH parameter
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

endpackage : serial_adder_pkg

// File: rtl/fa.sv
// -----------------------------------------------------------------------------
// fa
//   Single-bit full adder used as the bit datapath of serial_adder.
//   Ports:
//     A, B  : operand bits
//     Cin   : carry in
//     Sum   : A ^ B ^ Cin
//     Cout  : majority(A, B, Cin)
// -----------------------------------------------------------------------------
module fa (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule : fa

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder, LSB first, built around one full adder with a
//   registered carry. One addition takes WIDTH+2 clocks including both
//   handshakes.
//
//   Optional feature (macro SERIAL_ADDER_OVF_EN): adds output Ovf, the signed
//   two's-complement overflow, registered alongside Cout.
//
//   Ports:
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset
//     in_valid   : A, B, Cin valid
//     in_ready   : block accepts operands (IDLE only)
//     A, B       : WIDTH-bit operands
//     Cin        : carry into the LSB
//     out_valid  : Sum/Cout (and Ovf) valid (DONE only)
//     out_ready  : consumer takes the result
//     Sum        : registered (A + B + Cin) mod 2^WIDTH
//     Cout       : registered carry out of the MSB
//     Ovf        : (SERIAL_ADDER_OVF_EN only) signed overflow
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready depends only on state, never on in_valid; out_valid
//   stays high with Sum/Cout frozen until out_ready is seen high at an edge.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             cy;
    logic [CNT_W-1:0] count;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic [WIDTH:0]   sum_cat;
    logic [WIDTH-1:0] sum_next;

    fa u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (cy),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // Right shift with the new bit entering at the MSB. Built from a WIDTH+1
    // concatenation so WIDTH=1 needs no special case.
    assign sum_cat  = {fa_sum, sum_sh};
    assign sum_next = sum_cat[WIDTH:1];
    assign last_bit = (count == CNT_W'(WIDTH - 1));

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cy     <= 1'b0;
            count  <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        cy    <= Cin;
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    cy     <= fa_cout;
                    count  <= count + CNT_W'(1);
                    if (last_bit) begin
                        Sum   <= sum_next;
                        Cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // cy holds the carry into the MSB on the last bit.
                        Ovf   <= cy ^ fa_cout;
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : serial_adder
